// File: rtl/snake_pkg.sv
// Shared definitions for the snake movement engine: direction encoding,
// default grid size, reset-head helper and FSM state encoding.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_CHECK = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Reset head sits at the centre cell of each axis.
  function automatic int grid_center(input int extent);
    return extent / 2;
  endfunction

  // Opposite directions differ only in bit 1 with this encoding.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/snake_seg_buf.sv
// Snake body segment buffer: shift-and-insert-head storage, a combinational
// index port for the collision scan and a registered read port.
module snake_seg_buf import snake_pkg::*; #(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int LEN_W    = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             shift_en,
  input  logic [X_W-1:0]   new_x,
  input  logic [Y_W-1:0]   new_y,
  input  logic [LEN_W-1:0] chk_idx,
  output logic [X_W-1:0]   chk_x,
  output logic [Y_W-1:0]   chk_y,
  input  logic [LEN_W-1:0] length,
  input  logic [LEN_W-1:0] rd_idx,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic             rd_valid
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [X_W-1:0] seg_x_r [MAX_LEN];
  logic [Y_W-1:0] seg_y_r [MAX_LEN];

  // Body storage: reset to a horizontal snake left of centre, shift on step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          seg_x_r[i] <= X_W'(grid_center(GRID_W) - i);
          seg_y_r[i] <= Y_W'(grid_center(GRID_H));
        end else begin
          seg_x_r[i] <= {X_W{1'b0}};
          seg_y_r[i] <= {Y_W{1'b0}};
        end
      end
    end else if (shift_en) begin
      for (int i = MAX_LEN - 1; i > 0; i--) begin
        seg_x_r[i] <= seg_x_r[i-1];
        seg_y_r[i] <= seg_y_r[i-1];
      end
      seg_x_r[0] <= new_x;
      seg_y_r[0] <= new_y;
    end
  end

  // Collision-scan tap; the FSM keeps chk_idx below MAX_LEN.
  always_comb begin
    chk_x = seg_x_r[chk_idx[IDX_W-1:0]];
    chk_y = seg_y_r[chk_idx[IDX_W-1:0]];
  end

  // Registered read port for the render stage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_x     <= {X_W{1'b0}};
      rd_y     <= {Y_W{1'b0}};
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (rd_idx < length);
      if (rd_idx < LEN_W'(MAX_LEN)) begin
        rd_x <= seg_x_r[rd_idx[IDX_W-1:0]];
        rd_y <= seg_y_r[rd_idx[IDX_W-1:0]];
      end else begin
        rd_x <= {X_W{1'b0}};
        rd_y <= {Y_W{1'b0}};
      end
    end
  end

endmodule

// File: rtl/snake_mover.sv
// Snake movement and self-collision engine. Define SNAKE_WRAP_EN to make the
// head wrap at grid edges instead of ending the game.
module snake_mover import snake_pkg::*; #(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int LEN_W    = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             move_tick,
  input  logic             dir_valid,
  input  logic [1:0]       dir_req,
  input  logic             grow,
  input  logic [LEN_W-1:0] rd_idx,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic             rd_valid,
  output logic [X_W-1:0]   head_x,
  output logic [Y_W-1:0]   head_y,
  output logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             step_done,
  output logic             game_over
);

`ifdef SNAKE_WRAP_EN
  localparam logic EDGE_KILL = 1'b0;
`else
  localparam logic EDGE_KILL = 1'b1;
`endif

  state_t           state_r;
  logic [1:0]       dir_r, next_dir_r, ref_dir_s;
  logic             grow_pending_r, busy_r, step_done_r, game_over_r;
  logic [LEN_W-1:0] length_r, idx_r;
  logic [X_W-1:0]   head_x_r, new_x_s, chk_x_s;
  logic [Y_W-1:0]   head_y_r, new_y_s, chk_y_s;
  logic             off_grid_s, shift_en_s;

  assign shift_en_s = (state_r == ST_SHIFT) && !off_grid_s;
  // During SHIFT the pending direction becomes current, so reversal is judged against it.
  assign ref_dir_s  = (state_r == ST_SHIFT) ? next_dir_r : dir_r;

  // Next head cell; the wrapped value is only stored when edges do not kill.
  always_comb begin
    new_x_s    = head_x_r;
    new_y_s    = head_y_r;
    off_grid_s = 1'b0;
    case (next_dir_r)
      DIR_UP: begin
        if (head_y_r == {Y_W{1'b0}}) begin
          new_y_s = Y_W'(GRID_H - 1); off_grid_s = EDGE_KILL;
        end else begin
          new_y_s = head_y_r - Y_W'(1);
        end
      end
      DIR_RIGHT: begin
        if (head_x_r == X_W'(GRID_W - 1)) begin
          new_x_s = {X_W{1'b0}}; off_grid_s = EDGE_KILL;
        end else begin
          new_x_s = head_x_r + X_W'(1);
        end
      end
      DIR_DOWN: begin
        if (head_y_r == Y_W'(GRID_H - 1)) begin
          new_y_s = {Y_W{1'b0}}; off_grid_s = EDGE_KILL;
        end else begin
          new_y_s = head_y_r + Y_W'(1);
        end
      end
      DIR_LEFT: begin
        if (head_x_r == {X_W{1'b0}}) begin
          new_x_s = X_W'(GRID_W - 1); off_grid_s = EDGE_KILL;
        end else begin
          new_x_s = head_x_r - X_W'(1);
        end
      end
      default: begin
        off_grid_s = 1'b0;
      end
    endcase
  end

  // Step FSM with direction/grow request latching and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      dir_r          <= DIR_RIGHT;
      next_dir_r     <= DIR_RIGHT;
      grow_pending_r <= 1'b0;
      length_r       <= LEN_W'(INIT_LEN);
      head_x_r       <= X_W'(grid_center(GRID_W));
      head_y_r       <= Y_W'(grid_center(GRID_H));
      idx_r          <= LEN_W'(1);
      busy_r         <= 1'b0;
      step_done_r    <= 1'b0;
      game_over_r    <= 1'b0;
    end else begin
      step_done_r <= 1'b0;
      if (dir_valid && !is_reverse(dir_req, ref_dir_s)) begin
        next_dir_r <= dir_req;
      end
      // A grow arriving on the consuming edge wins, so it carries to the next step.
      if (grow) begin
        grow_pending_r <= 1'b1;
      end else if (shift_en_s) begin
        grow_pending_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (move_tick && !game_over_r) begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          dir_r <= next_dir_r;
          idx_r <= LEN_W'(1);
          if (off_grid_s) begin
            game_over_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            head_x_r <= new_x_s;
            head_y_r <= new_y_s;
            if (grow_pending_r && (length_r < LEN_W'(MAX_LEN))) begin
              length_r <= length_r + LEN_W'(1);
            end
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if ((chk_x_s == head_x_r) && (chk_y_s == head_y_r)) begin
            game_over_r <= 1'b1;
            state_r     <= ST_DONE;
          end else if (idx_r == (length_r - LEN_W'(1))) begin
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + LEN_W'(1);
          end
        end
        ST_DONE: begin
          step_done_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  snake_seg_buf #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W),
    .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .LEN_W(LEN_W)
  ) u_seg_buf (
    .clk      (clk),
    .resetn   (resetn),
    .shift_en (shift_en_s),
    .new_x    (new_x_s),
    .new_y    (new_y_s),
    .chk_idx  (idx_r),
    .chk_x    (chk_x_s),
    .chk_y    (chk_y_s),
    .length   (length_r),
    .rd_idx   (rd_idx),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_valid (rd_valid)
  );

  assign head_x    = head_x_r;
  assign head_y    = head_y_r;
  assign length    = length_r;
  assign busy      = busy_r;
  assign step_done = step_done_r;
  assign game_over = game_over_r;

endmodule
